// File: rtl/audio_ctrl_if.sv
// Control bundle between the key/codec side and the record/playback FSM.
// Ports: i_* inputs to the controller, o_* registered controller outputs.
interface audio_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int SPD_W  = 3
);
  logic              i_init_done;
  logic              i_key_0;
  logic              i_key_1;
  logic              i_key_2;
  logic [SPD_W-1:0]  i_speed;
  logic              i_fast;
  logic              i_interp;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_valid;
  logic [ADDR_W-1:0] i_play_addr;
  logic              o_i2c_start;
  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_play_start;
  logic              o_play_pause;
  logic              o_play_stop;
  logic              o_player_en;
  logic              o_sram_rec_sel;
  logic [SPD_W-1:0]  o_speed;
  logic              o_fast;
  logic              o_slow_0;
  logic              o_slow_1;
  logic [ADDR_W-1:0] o_rec_end_addr;
  logic              o_has_rec;
  logic [2:0]        o_state;

  modport master (
    output i_init_done, i_key_0, i_key_1, i_key_2,
    output i_speed, i_fast, i_interp,
    output i_rec_addr, i_rec_valid, i_play_addr,
    input  o_i2c_start,
    input  o_rec_start, o_rec_pause, o_rec_stop,
    input  o_play_start, o_play_pause, o_play_stop,
    input  o_player_en, o_sram_rec_sel,
    input  o_speed, o_fast, o_slow_0, o_slow_1,
    input  o_rec_end_addr, o_has_rec, o_state
  );

  modport slave (
    input  i_init_done, i_key_0, i_key_1, i_key_2,
    input  i_speed, i_fast, i_interp,
    input  i_rec_addr, i_rec_valid, i_play_addr,
    output o_i2c_start,
    output o_rec_start, o_rec_pause, o_rec_stop,
    output o_play_start, o_play_pause, o_play_stop,
    output o_player_en, o_sram_rec_sel,
    output o_speed, o_fast, o_slow_0, o_slow_1,
    output o_rec_end_addr, o_has_rec, o_state
  );
endinterface

// File: rtl/audio_ctrl_fsm.sv
// Record/playback control FSM: codec init, key commands, SRAM steering.
// Ports: i_clk, i_rst_n (async low), bus (audio_ctrl_if.slave).
module audio_ctrl_fsm #(
  parameter int ADDR_W = 20,
  parameter int SPD_W  = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  audio_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    IDLE       = 3'd1,
    RECD       = 3'd2,
    RECD_PAUSE = 3'd3,
    PLAY       = 3'd4,
    PLAY_PAUSE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              started_q, started_d;
  logic              i2c_q, i2c_d;
  logic              rs_q, rs_d, rp_q, rp_d, rx_q, rx_d;
  logic              ps_q, ps_d, pp_q, pp_d, px_q, px_d;
  logic              en_q, en_d, sel_q, sel_d;
  logic [SPD_W-1:0]  spd_q, spd_d;
  logic              fast_q, fast_d;
  logic              s0_q, s0_d, s1_q, s1_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              has_q, has_d;

  logic k0, k1, k2;
  logic full, eor, latch;

  // Only the highest-priority key of a cycle acts.
  assign k2 = bus.i_key_2;
  assign k0 = bus.i_key_0 & ~k2;
  assign k1 = bus.i_key_1 & ~bus.i_key_0 & ~k2;

  assign full = bus.i_rec_valid & (&bus.i_rec_addr);
  assign eor  = bus.i_play_addr >= end_q;

  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    i2c_d     = 1'b0;
    rs_d      = 1'b0;
    rp_d      = 1'b0;
    rx_d      = 1'b0;
    ps_d      = 1'b0;
    pp_d      = 1'b0;
    px_d      = 1'b0;
    end_d     = end_q;
    has_d     = has_q;
    latch     = 1'b0;
    unique case (state_q)
      INIT: begin
        started_d = 1'b1;
        i2c_d     = ~started_q;
        if (bus.i_init_done) state_d = IDLE;
      end
      IDLE: begin
        if (k0) begin
          state_d = RECD;
          rs_d    = 1'b1;
          has_d   = 1'b0;
        end else if (k1 && has_q) begin
          state_d = PLAY;
          ps_d    = 1'b1;
          latch   = 1'b1;
        end
      end
      RECD: begin
        if (bus.i_rec_valid) begin
          end_d = bus.i_rec_addr;
          has_d = 1'b1;
        end
        if (k2 || full) begin
          state_d = IDLE;
          rx_d    = 1'b1;
        end else if (k0) begin
          state_d = RECD_PAUSE;
          rp_d    = 1'b1;
        end
      end
      RECD_PAUSE: begin
        if (k2) begin
          state_d = IDLE;
          rx_d    = 1'b1;
        end else if (k0) begin
          state_d = RECD;
          rs_d    = 1'b1;
        end
      end
      PLAY: begin
        if (k2 || eor) begin
          state_d = IDLE;
          px_d    = 1'b1;
        end else if (k1) begin
          state_d = PLAY_PAUSE;
          pp_d    = 1'b1;
        end
      end
      PLAY_PAUSE: begin
        if (k2) begin
          state_d = IDLE;
          px_d    = 1'b1;
        end else if (k1) begin
          state_d = PLAY;
          ps_d    = 1'b1;
          latch   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    spd_d  = spd_q;
    fast_d = fast_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    // Speed 0 is normal playback, so no mode bit is set.
    if (latch) begin
      spd_d  = bus.i_speed;
      fast_d = (bus.i_speed != '0) & bus.i_fast;
      s1_d   = (bus.i_speed != '0) & ~bus.i_fast & bus.i_interp;
      s0_d   = (bus.i_speed != '0) & ~bus.i_fast & ~bus.i_interp;
    end

    sel_d = (state_d == RECD) || (state_d == RECD_PAUSE);
    en_d  = (state_d == PLAY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= INIT;
      started_q <= 1'b0;
      i2c_q     <= 1'b0;
      rs_q      <= 1'b0;
      rp_q      <= 1'b0;
      rx_q      <= 1'b0;
      ps_q      <= 1'b0;
      pp_q      <= 1'b0;
      px_q      <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= 1'b0;
      spd_q     <= '0;
      fast_q    <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      end_q     <= '0;
      has_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      i2c_q     <= i2c_d;
      rs_q      <= rs_d;
      rp_q      <= rp_d;
      rx_q      <= rx_d;
      ps_q      <= ps_d;
      pp_q      <= pp_d;
      px_q      <= px_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      spd_q     <= spd_d;
      fast_q    <= fast_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      end_q     <= end_d;
      has_q     <= has_d;
    end
  end

  assign bus.o_i2c_start    = i2c_q;
  assign bus.o_rec_start    = rs_q;
  assign bus.o_rec_pause    = rp_q;
  assign bus.o_rec_stop     = rx_q;
  assign bus.o_play_start   = ps_q;
  assign bus.o_play_pause   = pp_q;
  assign bus.o_play_stop    = px_q;
  assign bus.o_player_en    = en_q;
  assign bus.o_sram_rec_sel = sel_q;
  assign bus.o_speed        = spd_q;
  assign bus.o_fast         = fast_q;
  assign bus.o_slow_0       = s0_q;
  assign bus.o_slow_1       = s1_q;
  assign bus.o_rec_end_addr = end_q;
  assign bus.o_has_rec      = has_q;
  assign bus.o_state        = state_q;

endmodule

// File: tb/tb_audio_ctrl_fsm.sv
// Self-checking bench for audio_ctrl_fsm.
// Cycle model plus directed literal checks.
module tb_audio_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  audio_ctrl_if bus ();

  audio_ctrl_fsm dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---- behavioural model (mode as plain int) ----
  int        m_st = 0;
  bit        m_first = 1'b1;
  bit        m_i2c, m_rs, m_rp, m_rx, m_ps, m_pp, m_px;
  int        m_speed = 0;
  bit        m_fast, m_s0, m_s1;
  int        m_end = 0;
  bit        m_has;

  function automatic void m_clear();
    m_i2c = 0; m_rs = 0; m_rp = 0; m_rx = 0;
    m_ps = 0; m_pp = 0; m_px = 0;
  endfunction

  function automatic void m_latch();
    int s;
    s = int'(bus.i_speed);
    m_speed = s;
    m_fast = (s != 0) && bus.i_fast;
    m_s1 = (s != 0) && !bus.i_fast && bus.i_interp;
    m_s0 = (s != 0) && !bus.i_fast && !bus.i_interp;
  endfunction

  function automatic void m_step();
    bit a2, a0, a1, full, eor;
    int ra, pa;
    a2 = bus.i_key_2;
    a0 = bus.i_key_0 && !a2;
    a1 = bus.i_key_1 && !bus.i_key_0 && !a2;
    ra = int'(bus.i_rec_addr);
    pa = int'(bus.i_play_addr);
    full = bus.i_rec_valid && (ra == 1048575);
    eor = pa >= m_end;
    m_clear();
    if (m_st == 0) begin
      m_i2c = m_first;
      m_first = 0;
      if (bus.i_init_done) m_st = 1;
    end else if (m_st == 1) begin
      if (a0) begin
        m_st = 2; m_rs = 1; m_has = 0;
      end else if (a1 && m_has) begin
        m_st = 4; m_ps = 1; m_latch();
      end
    end else if (m_st == 2) begin
      if (bus.i_rec_valid) begin
        m_end = ra; m_has = 1;
      end
      if (a2 || full) begin
        m_st = 1; m_rx = 1;
      end else if (a0) begin
        m_st = 3; m_rp = 1;
      end
    end else if (m_st == 3) begin
      if (a2) begin
        m_st = 1; m_rx = 1;
      end else if (a0) begin
        m_st = 2; m_rs = 1;
      end
    end else if (m_st == 4) begin
      if (a2 || eor) begin
        m_st = 1; m_px = 1;
      end else if (a1) begin
        m_st = 5; m_pp = 1;
      end
    end else if (m_st == 5) begin
      if (a2) begin
        m_st = 1; m_px = 1;
      end else if (a1) begin
        m_st = 4; m_ps = 1; m_latch();
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_clear();
      m_st = 0; m_first = 1; m_speed = 0;
      m_fast = 0; m_s0 = 0; m_s1 = 0;
      m_end = 0; m_has = 0;
    end else begin
      m_step();
    end
  end

  function automatic logic [38:0] exp_vec();
    bit en, sel;
    en = (m_st == 4);
    sel = (m_st == 2) || (m_st == 3);
    return {m_i2c, m_rs, m_rp, m_rx, m_ps, m_pp, m_px,
            en, sel, 3'(m_speed), m_fast, m_s0, m_s1,
            20'(m_end), m_has, 3'(m_st)};
  endfunction

  function automatic logic [38:0] act_vec();
    return {bus.o_i2c_start, bus.o_rec_start,
            bus.o_rec_pause, bus.o_rec_stop,
            bus.o_play_start, bus.o_play_pause,
            bus.o_play_stop, bus.o_player_en,
            bus.o_sram_rec_sel, bus.o_speed,
            bus.o_fast, bus.o_slow_0, bus.o_slow_1,
            bus.o_rec_end_addr, bus.o_has_rec,
            bus.o_state};
  endfunction

  // ---- pulse counters and per-cycle compare ----
  int c_i2c = 0, c_rs = 0, c_rp = 0, c_rx = 0;
  int c_ps = 0, c_pp = 0, c_px = 0;

  initial forever begin
    @(negedge clk);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cycle_model t=%0t got=%h want=%h",
               $time, act_vec(), exp_vec());
    end
    c_i2c += int'(bus.o_i2c_start);
    c_rs  += int'(bus.o_rec_start);
    c_rp  += int'(bus.o_rec_pause);
    c_rx  += int'(bus.o_rec_stop);
    c_ps  += int'(bus.o_play_start);
    c_pp  += int'(bus.o_play_pause);
    c_px  += int'(bus.o_play_stop);
  end

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic keys(input bit a0, input bit a1,
                      input bit a2);
    bus.i_key_0 = a0;
    bus.i_key_1 = a1;
    bus.i_key_2 = a2;
    @(negedge clk);
    bus.i_key_0 = 0;
    bus.i_key_1 = 0;
    bus.i_key_2 = 0;
  endtask

  task automatic rec_words(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.i_rec_valid = 1;
      bus.i_rec_addr = 20'(i);
      @(negedge clk);
    end
    bus.i_rec_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    bus.i_init_done = 0;
    bus.i_key_0 = 0;
    bus.i_key_1 = 0;
    bus.i_key_2 = 0;
    bus.i_speed = '0;
    bus.i_fast = 0;
    bus.i_interp = 0;
    bus.i_rec_addr = '0;
    bus.i_rec_valid = 0;
    bus.i_play_addr = '0;
    tick(3);
    chk("rst_all_zero", longint'(act_vec()), 0);

    // init: i2c pulse once, keys ignored, done at cycle 10
    rst_n = 1;
    tick(1);
    chk("i2c_cycle1", bus.o_i2c_start, 1);
    tick(3);
    keys(1, 0, 0);
    tick(4);
    chk("init_hold", bus.o_state, 0);
    chk("i2c_once", c_i2c, 1);
    bus.i_init_done = 1;
    tick(1);
    chk("init_to_idle", bus.o_state, 1);

    // record 0..99 then stop
    keys(1, 0, 0);
    chk("rec_sel", bus.o_sram_rec_sel, 1);
    rec_words(0, 99);
    keys(0, 0, 1);
    tick(1);
    chk("rec_end_99", bus.o_rec_end_addr, 99);
    chk("rec_has", bus.o_has_rec, 1);
    chk("rec_idle", bus.o_state, 1);
    chk("rec_start_cnt", c_rs, 1);
    chk("rec_stop_cnt", c_rx, 1);

    // slow linear play, pause, re-latch, run to end
    bus.i_speed = 3'd3;
    bus.i_fast = 0;
    bus.i_interp = 1;
    bus.i_play_addr = '0;
    keys(0, 1, 0);
    chk("play_speed3", bus.o_speed, 3);
    chk("play_slow1", bus.o_slow_1, 1);
    chk("play_en", bus.o_player_en, 1);
    for (int i = 1; i <= 50; i++) begin
      bus.i_play_addr = 20'(i);
      tick(1);
    end
    keys(0, 1, 0);
    chk("pause_state", bus.o_state, 5);
    chk("pause_en", bus.o_player_en, 0);
    bus.i_speed = 3'd5;
    tick(1);
    chk("pause_speed_held", bus.o_speed, 3);
    keys(0, 1, 0);
    chk("resume_speed5", bus.o_speed, 5);
    for (int i = 51; i <= 99; i++) begin
      bus.i_play_addr = 20'(i);
      tick(1);
    end
    tick(1);
    chk("play_end_idle", bus.o_state, 1);
    chk("play_start_cnt", c_ps, 2);
    chk("play_stop_cnt", c_px, 1);

    // record with pause, then all three keys at once
    keys(1, 0, 0);
    rec_words(0, 4);
    keys(1, 0, 0);
    chk("recpause_state", bus.o_state, 3);
    keys(1, 0, 0);
    rec_words(5, 9);
    keys(1, 1, 1);
    tick(1);
    chk("tri_key_idle", bus.o_state, 1);
    chk("tri_key_stop", c_rx, 2);
    chk("tri_key_pause", c_rp, 1);
    chk("tri_key_end", bus.o_rec_end_addr, 9);

    // memory full auto-stop
    keys(1, 0, 0);
    rec_words(1048574, 1048575);
    tick(1);
    chk("full_idle", bus.o_state, 1);
    chk("full_end", bus.o_rec_end_addr, 20'hFFFFF);
    chk("full_stop_cnt", c_rx, 3);

    // fast play; key_2 coincides with end of recording
    bus.i_speed = 3'd2;
    bus.i_fast = 1;
    bus.i_play_addr = '0;
    keys(0, 1, 0);
    chk("fast_bit", bus.o_fast, 1);
    chk("fast_state", bus.o_state, 4);
    bus.i_play_addr = 20'hFFFFF;
    keys(0, 0, 1);
    bus.i_play_addr = '0;
    tick(2);
    chk("coincide_stop", c_px, 2);

    // reset asserted during play
    keys(0, 1, 0);
    tick(3);
    chk("pre_rst_play", bus.o_state, 4);
    #2 rst_n = 0;
    #1 chk("midrst_zero", longint'(act_vec()), 0);
    tick(2);
    rst_n = 1;
    tick(4);
    chk("post_rst_i2c", c_i2c, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
